// File: rtl/pwm_cap_pkg.sv
// pwm_cap_pkg: shared types and defaults for the PWM capture block.
// Holds the capture FSM state encoding and default counter/timeout sizes.
package pwm_cap_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } state_e;

   localparam int CNT_W_DEF   = 20;
   localparam int TIMEOUT_DEF = 1_000_000;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-FF synchronizer plus one delay flop with edge strobes.
// Ports: clk, rst_n (sync, active-low), din (async in),
//        s (synced level), rise / fall (one-cycle edge strobes).
module sync_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic s,
   output logic rise,
   output logic fall
);

   logic meta_q;
   logic sync_q;
   logic dly_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         dly_q  <= 1'b0;
      end else begin
         meta_q <= din;
         sync_q <= meta_q;
         dly_q  <= sync_q;
      end
   end

   assign s    = sync_q;
   assign rise = sync_q & ~dly_q;
   assign fall = ~sync_q & dly_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of a PWM input in clk cycles.
// Ports: clk, rst_n, en, pwm_in -> high_cnt, period_cnt, valid, timeout,
//        stuck_high (line level latched when the timeout fired).
module pwm_capture
   import pwm_cap_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic             valid,
   output logic             timeout,
   output logic             stuck_high
);

   localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);

   logic s;
   logic rise;
   logic fall;

   state_e           state_q;
   logic [CNT_W-1:0] hi_q;
   logic [CNT_W-1:0] per_q;
   logic [CNT_W-1:0] idle_q;
   logic [CNT_W-1:0] high_cnt_q;
   logic [CNT_W-1:0] period_cnt_q;
   logic             valid_q;
   logic             timeout_q;
   logic             stuck_q;

   // Counters stop at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + ONE;
   endfunction

   sync_edge_det u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (pwm_in),
      .s     (s),
      .rise  (rise),
      .fall  (fall)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         hi_q         <= '0;
         per_q        <= '0;
         idle_q       <= '0;
         high_cnt_q   <= '0;
         period_cnt_q <= '0;
         valid_q      <= 1'b0;
         timeout_q    <= 1'b0;
         stuck_q      <= 1'b0;
      end else if (!en) begin
         state_q <= IDLE;
         hi_q    <= '0;
         per_q   <= '0;
         idle_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         idle_q  <= (rise || fall) ? '0 : sat_inc(idle_q);
         // A rise outranks the timeout threshold in the same cycle.
         if (rise) begin
            timeout_q <= 1'b0;
            hi_q      <= ONE;
            per_q     <= ONE;
            state_q   <= HIGH;
            if (state_q == LOW) begin
               high_cnt_q   <= hi_q;
               period_cnt_q <= per_q;
               valid_q      <= 1'b1;
            end
         end else if (idle_q == TO_LIM) begin
            timeout_q <= 1'b1;
            stuck_q   <= s;
            state_q   <= IDLE;
            hi_q      <= '0;
            per_q     <= '0;
         end else begin
            unique case (state_q)
               HIGH: begin
                  per_q <= sat_inc(per_q);
                  // The fall cycle is already low: period only.
                  if (fall) begin
                     state_q <= LOW;
                  end else begin
                     hi_q <= sat_inc(hi_q);
                  end
               end
               LOW: begin
                  per_q <= sat_inc(per_q);
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign high_cnt   = high_cnt_q;
   assign period_cnt = period_cnt_q;
   assign valid      = valid_q;
   assign timeout    = timeout_q;
   assign stuck_high = stuck_q;

endmodule
